// File: rtl/axil_uart_vport_if.sv
// AXI4-Lite channel bundle between the shell and the UART virtual port.
interface axil_uart_vport_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_uart_vport.sv
// 16550-style register front end (reg-shift 2) on AXI4-Lite whose serial
// PHY is replaced by TX/RX byte streams with valid/ready handshakes.
module axil_uart_vport #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 13
) (
    input  logic             chipset_clk,
    input  logic             chipset_rstn,
    axil_uart_vport_if.slave s_axi,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             uart_irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    // Write channel state
    logic              aw_held_reg;
    logic [ADDR_W-1:0] awaddr_reg;
    logic              w_held_reg;
    logic [7:0]        wdata_reg;
    logic              bvalid_reg;
    logic [1:0]        bresp_reg;

    // Read channel state
    logic              rvalid_reg;
    logic [1:0]        rresp_reg;
    logic [7:0]        rdata_reg;

    // UART registers
    logic [1:0]        ier_reg;
    logic [7:0]        lcr_reg;
    logic [7:0]        mcr_reg;
    logic [7:0]        scr_reg;
    logic [7:0]        dll_reg;
    logic [7:0]        dlm_reg;
    logic              irq_reg;

    // Byte FIFOs
    logic [7:0]        tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wr_ptr_reg;
    logic [PTR_W-1:0]  tx_rd_ptr_reg;
    logic [CNT_W-1:0]  tx_count_reg;
    logic [7:0]        rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rx_wr_ptr_reg;
    logic [PTR_W-1:0]  rx_rd_ptr_reg;
    logic [CNT_W-1:0]  rx_count_reg;

    logic aw_hs, w_hs, ar_hs, wr_exec, wr_mapped, rd_mapped, dlab;
    logic [2:0] wr_idx, rd_idx;
    logic tx_push, tx_pop, tx_clr, rx_push, rx_pop, rx_clr, fcr_wr;
    logic tx_empty, rx_nonempty;
    logic [7:0] lsr, iir, rd_value;
    logic unused_bits;

    // Only the low data byte and the word-aligned address bits carry meaning.
    assign unused_bits = ^{s_axi.wdata[31:8], s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = chipset_rstn & !aw_held_reg & !bvalid_reg;
    assign s_axi.wready  = chipset_rstn & !w_held_reg & !bvalid_reg;
    assign s_axi.arready = chipset_rstn & !rvalid_reg;
    assign s_axi.bvalid  = bvalid_reg;
    assign s_axi.bresp   = bresp_reg;
    assign s_axi.rvalid  = rvalid_reg;
    assign s_axi.rresp   = rresp_reg;
    assign s_axi.rdata   = {24'h0, rdata_reg};

    assign aw_hs = s_axi.awvalid & s_axi.awready;
    assign w_hs  = s_axi.wvalid & s_axi.wready;
    assign ar_hs = s_axi.arvalid & s_axi.arready;

    assign dlab      = lcr_reg[7];
    assign wr_exec   = aw_held_reg & w_held_reg & !bvalid_reg;
    assign wr_idx    = awaddr_reg[4:2];
    assign wr_mapped = (awaddr_reg[ADDR_W-1:5] == '0);
    assign rd_idx    = s_axi.araddr[4:2];
    assign rd_mapped = (s_axi.araddr[ADDR_W-1:5] == '0);

    assign tx_empty    = (tx_count_reg == '0);
    assign rx_nonempty = (rx_count_reg != '0);

    assign tx_valid = !tx_empty;
    assign tx_byte  = tx_mem[tx_rd_ptr_reg];
    assign rx_ready = (rx_count_reg < FULL_CNT) & chipset_rstn;
    assign uart_irq = irq_reg;

    // A full TX FIFO drops the byte even if it drains in the same cycle.
    assign tx_push = wr_exec & wr_mapped & (wr_idx == 3'd0) & !dlab & (tx_count_reg != FULL_CNT);
    assign tx_pop  = tx_valid & tx_ready;
    assign fcr_wr  = wr_exec & wr_mapped & (wr_idx == 3'd2);
    assign tx_clr  = fcr_wr & wdata_reg[2];
    assign rx_clr  = fcr_wr & wdata_reg[1];
    assign rx_push = rx_valid & rx_ready;
    assign rx_pop  = ar_hs & rd_mapped & (rd_idx == 3'd0) & !dlab & rx_nonempty;

    assign lsr = {1'b0, tx_empty, tx_empty, 4'b0000, rx_nonempty};

    // Interrupt identification, RX data has priority over THR empty.
    always_comb begin
        iir = 8'hC1;
        if (ier_reg[0] & rx_nonempty) begin
            iir = 8'hC4;
        end else if (ier_reg[1] & tx_empty) begin
            iir = 8'hC2;
        end
    end

    // Read data selection for the address presented on AR.
    always_comb begin
        rd_value = 8'h00;
        case (rd_idx)
            3'd0:    rd_value = dlab ? dll_reg : (rx_nonempty ? rx_mem[rx_rd_ptr_reg] : 8'h00);
            3'd1:    rd_value = dlab ? dlm_reg : {6'b0, ier_reg};
            3'd2:    rd_value = iir;
            3'd3:    rd_value = lcr_reg;
            3'd4:    rd_value = mcr_reg;
            3'd5:    rd_value = lsr;
            3'd6:    rd_value = 8'hB0;
            default: rd_value = scr_reg;
        endcase
        if (!rd_mapped) begin
            rd_value = 8'h00;
        end
    end

    // AXI write/read channel sequencing.
    always_ff @(posedge chipset_clk) begin
        if (!chipset_rstn) begin
            aw_held_reg <= 1'b0;
            awaddr_reg  <= '0;
            w_held_reg  <= 1'b0;
            wdata_reg   <= 8'h00;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            rvalid_reg  <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= 8'h00;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                awaddr_reg  <= s_axi.awaddr;
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_axi.wdata[7:0];
            end
            if (wr_exec) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_reg & s_axi.bready) begin
                bvalid_reg <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_value;
                rresp_reg  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_reg & s_axi.rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    // Register file updates and the registered interrupt line.
    always_ff @(posedge chipset_clk) begin
        if (!chipset_rstn) begin
            ier_reg <= 2'b00;
            lcr_reg <= 8'h00;
            mcr_reg <= 8'h00;
            scr_reg <= 8'h00;
            dll_reg <= 8'h00;
            dlm_reg <= 8'h00;
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= (ier_reg[0] & rx_nonempty) | (ier_reg[1] & tx_empty);
            if (wr_exec & wr_mapped) begin
                case (wr_idx)
                    3'd0: if (dlab) dll_reg <= wdata_reg;
                    3'd1: if (dlab) dlm_reg <= wdata_reg; else ier_reg <= wdata_reg[1:0];
                    3'd3: lcr_reg <= wdata_reg;
                    3'd4: mcr_reg <= wdata_reg;
                    3'd7: scr_reg <= wdata_reg;
                    default: ;
                endcase
            end
        end
    end

    // FIFO storage; pointers alone define content so no reset is needed.
    always_ff @(posedge chipset_clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= wdata_reg;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= rx_byte;
        end
    end

    // TX FIFO pointers and occupancy; a clear overrides push and pop.
    always_ff @(posedge chipset_clk) begin
        if (!chipset_rstn || tx_clr) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_W'(1);
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_W'(1);
            if (tx_push && !tx_pop) begin
                tx_count_reg <= tx_count_reg + CNT_W'(1);
            end else if (!tx_push && tx_pop) begin
                tx_count_reg <= tx_count_reg - CNT_W'(1);
            end
        end
    end

    // RX FIFO pointers and occupancy; a clear overrides push and pop.
    always_ff @(posedge chipset_clk) begin
        if (!chipset_rstn || rx_clr) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_W'(1);
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_W'(1);
            if (rx_push && !rx_pop) begin
                rx_count_reg <= rx_count_reg + CNT_W'(1);
            end else if (!rx_push && rx_pop) begin
                rx_count_reg <= rx_count_reg - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_axil_uart_vport.sv
// Directed and randomized bench for the AXI-Lite UART virtual port.
`timescale 1ns/1ps
module tb_axil_uart_vport;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       uart_irq;

    axil_uart_vport_if #(.ADDR_W(13)) s_axi ();

    axil_uart_vport #(.FIFO_DEPTH(16), .ADDR_W(13)) dut (
        .chipset_clk (clk),
        .chipset_rstn(rstn),
        .s_axi       (s_axi),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .uart_irq    (uart_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: FIFOs as queues, registers as plain variables.
    byte unsigned tx_q[$];
    byte unsigned rx_q[$];
    logic [1:0]   m_ier = 2'b00;
    logic [7:0]   m_scr = 8'h00;
    logic [7:0]   m_mcr = 8'h00;
    logic [7:0]   m_lcr = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_lsr();
        logic thre;
        logic dr;
        thre = (tx_q.size() == 0);
        dr   = (rx_q.size() != 0);
        return {1'b0, thre, thre, 4'b0000, dr};
    endfunction

    function automatic logic [7:0] exp_iir();
        if (m_ier[0] && rx_q.size() != 0) return 8'hC4;
        if (m_ier[1] && tx_q.size() == 0) return 8'hC2;
        return 8'hC1;
    endfunction

    function automatic logic exp_irq();
        return (m_ier[0] && rx_q.size() != 0) || (m_ier[1] && tx_q.size() == 0);
    endfunction

    task automatic axi_write(input logic [12:0] addr, input logic [7:0] data, output logic [1:0] resp);
        logic aw_done, w_done, aw_fire, w_fire;
        int n;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        s_axi.awaddr  = addr;
        s_axi.awvalid = 1'b1;
        s_axi.wdata   = {24'($urandom), data};
        s_axi.wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_fire = s_axi.awvalid && s_axi.awready;
            w_fire  = s_axi.wvalid && s_axi.wready;
            tick();
            n++;
            if (aw_fire) begin s_axi.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_fire)  begin s_axi.wvalid  = 1'b0; w_done  = 1'b1; end
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        n = 0;
        while (!s_axi.bvalid && n < 50) begin tick(); n++; end
        if (!s_axi.bvalid) check("write_bvalid_timeout", 32'(s_axi.bvalid), 32'd1);
        resp = s_axi.bresp;
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [12:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic fire;
        int n;
        n = 0;
        fire = 1'b0;
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        while (!fire && n < 50) begin
            fire = s_axi.arready;
            tick();
            n++;
        end
        s_axi.arvalid = 1'b0;
        n = 0;
        while (!s_axi.rvalid && n < 50) begin tick(); n++; end
        if (!s_axi.rvalid) check("read_rvalid_timeout", 32'(s_axi.rvalid), 32'd1);
        data = s_axi.rdata;
        resp = s_axi.rresp;
        s_axi.rready = 1'b1;
        tick();
        s_axi.rready = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        int n;
        n = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin tick(); n++; end
        if (!rx_ready) check("rx_push_timeout", 32'(rx_ready), 32'd1);
        else rx_q.push_back(b);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic drain_tx(input string tag);
        int n;
        n = 0;
        tx_ready = 1'b1;
        while (tx_q.size() > 0 && n < 200) begin
            if (tx_valid) check(tag, 32'(tx_byte), 32'(tx_q.pop_front()));
            tick();
            n++;
        end
        tx_ready = 1'b0;
        if (tx_q.size() != 0) begin
            check({tag, "_timeout"}, 32'(tx_q.size()), 32'd0);
            tx_q.delete();
        end
        check({tag, "_empty"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic [7:0]  b;
        int lat;
        int op;

        s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b0; s_axi.araddr = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", 32'(s_axi.awready), 32'd0);
        check("rst_wready",  32'(s_axi.wready),  32'd0);
        check("rst_arready", 32'(s_axi.arready), 32'd0);
        check("rst_bvalid",  32'(s_axi.bvalid),  32'd0);
        check("rst_rvalid",  32'(s_axi.rvalid),  32'd0);
        check("rst_rdata",   s_axi.rdata,        32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_irq",     32'(uart_irq), 32'd0);
        rstn = 1'b1;
        tick();

        axi_read(13'h14, rd, rsp);
        check("lsr_after_reset", rd, 32'h60);
        check("lsr_rresp", 32'(rsp), 32'd0);
        check("idle_tx_valid", 32'(tx_valid), 32'd0);
        check("idle_rx_ready", 32'(rx_ready), 32'd1);
        check("idle_irq", 32'(uart_irq), 32'd0);
        axi_read(13'h18, rd, rsp);
        check("msr", rd, 32'hB0);

        // THR write with W leading AW by one cycle
        s_axi.wdata = 32'hDEAD_BE41; s_axi.wvalid = 1'b1;
        tick();
        s_axi.wvalid = 1'b0;
        s_axi.awaddr = 13'h0; s_axi.awvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0;
        lat = 0;
        while (!s_axi.bvalid && lat < 10) begin tick(); lat++; end
        check("wlead_latency", 32'(lat), 32'd1);
        check("wlead_bresp", 32'(s_axi.bresp), 32'd0);
        check("wlead_tx_valid", 32'(tx_valid), 32'd1);
        check("wlead_tx_byte", 32'(tx_byte), 32'h41);
        s_axi.bready = 1'b1; tick(); s_axi.bready = 1'b0;
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        check("wlead_popped", 32'(tx_valid), 32'd0);
        axi_read(13'h14, rd, rsp);
        check("wlead_lsr", rd, 32'h60);

        // 17 THR writes into a 16-entry FIFO with the sink stalled
        for (int i = 0; i < 17; i++) begin
            axi_write(13'h0, 8'(i), rsp);
            check($sformatf("thr_fill_bresp_%0d", i), 32'(rsp), 32'd0);
            if (tx_q.size() < 16) tx_q.push_back(8'(i));
        end
        drain_tx("thr_fill_order");

        // RX interrupt path
        axi_write(13'h4, 8'h01, rsp); m_ier = 2'b01;
        tick();
        check("ier_rx_irq_idle", 32'(uart_irq), 32'd0);
        rx_byte = 8'h5A; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        lat = 0;
        while (!uart_irq && lat < 2) begin tick(); lat++; end
        check("rx_irq_rise", 32'(uart_irq), 32'd1);
        axi_read(13'h8, rd, rsp);
        check("iir_rx", rd, 32'hC4);
        axi_read(13'h0, rd, rsp);
        check("rbr_5a", rd, 32'h5A);
        check("rx_irq_fall", 32'(uart_irq), 32'd0);
        axi_read(13'h14, rd, rsp);
        check("lsr_rx_drained", rd & 32'h1, 32'd0);

        // Fill RX FIFO to back-pressure, check order, then flush via FCR
        b = 8'($urandom);
        for (int i = 0; i < 16; i++) rx_push(b + 8'(i * 7));
        check("rx_full_ready", 32'(rx_ready), 32'd0);
        rx_byte = 8'hEE; rx_valid = 1'b1;
        repeat (2) tick();
        check("rx_full_hold", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi_read(13'h0, rd, rsp);
            check("rx_order", rd, 32'(rx_q.pop_front()));
        end
        rx_push(8'h11); rx_push(8'h22);
        check("rx_refull_ready", 32'(rx_ready), 32'd0);
        axi_write(13'h8, 8'h02, rsp); rx_q.delete();
        check("fcr_rx_ready", 32'(rx_ready), 32'd1);
        axi_read(13'h14, rd, rsp);
        check("fcr_rx_lsr", rd, 32'h60);

        // FCR TX clear
        for (int i = 0; i < 3; i++) axi_write(13'h0, 8'(8'hA0 + i), rsp);
        check("tx_before_clear", 32'(tx_valid), 32'd1);
        axi_write(13'h8, 8'h04, rsp);
        check("fcr_tx_clear", 32'(tx_valid), 32'd0);

        // Unmapped accesses
        axi_write(13'h1C, 8'h77, rsp); m_scr = 8'h77;
        axi_read(13'h40, rd, rsp);
        check("unmapped_rresp", 32'(rsp), 32'd2);
        check("unmapped_rdata", rd, 32'd0);
        axi_write(13'h5C, 8'hAA, rsp);
        check("unmapped_bresp", 32'(rsp), 32'd2);
        axi_read(13'h1C, rd, rsp);
        check("scr_untouched", rd, 32'h77);

        // Divisor latch access
        axi_write(13'hC, 8'h80, rsp);
        axi_write(13'h0, 8'h12, rsp);
        axi_write(13'h4, 8'h34, rsp);
        axi_read(13'h0, rd, rsp);
        check("dll_readback", rd, 32'h12);
        axi_read(13'h4, rd, rsp);
        check("dlm_readback", rd, 32'h34);
        check("dlab_tx_untouched", 32'(tx_valid), 32'd0);
        axi_write(13'hC, 8'h03, rsp); m_lcr = 8'h03;
        axi_read(13'h4, rd, rsp);
        check("ier_after_dlab", rd, 32'(m_ier));
        axi_read(13'h0, rd, rsp);
        check("rbr_empty", rd, 32'h00);

        // Randomized operations against the model
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 7));
            b  = 8'($urandom);
            case (op)
                0: begin axi_write(13'h1C, b, rsp); m_scr = b; end
                1: begin axi_read(13'h1C, rd, rsp); check("rnd_scr", rd, 32'(m_scr)); end
                2: begin
                    axi_write(13'h0, b, rsp);
                    check("rnd_thr_bresp", 32'(rsp), 32'd0);
                    if (tx_q.size() < 16) tx_q.push_back(b);
                end
                3: if (rx_q.size() < 16) rx_push(b);
                4: begin
                    axi_read(13'h0, rd, rsp);
                    check("rnd_rbr", rd, (rx_q.size() != 0) ? 32'(rx_q.pop_front()) : 32'd0);
                end
                5: begin axi_read(13'h14, rd, rsp); check("rnd_lsr", rd, 32'(exp_lsr())); end
                6: begin
                    axi_write(13'h4, b, rsp); m_ier = b[1:0];
                    axi_read(13'h8, rd, rsp); check("rnd_iir", rd, 32'(exp_iir()));
                end
                default: begin
                    axi_write(13'h10, b, rsp); m_mcr = b;
                    axi_read(13'h10, rd, rsp); check("rnd_mcr", rd, 32'(m_mcr));
                end
            endcase
            tick();
            check("rnd_irq", 32'(uart_irq), 32'(exp_irq()));
        end
        drain_tx("rnd_tx_order");

        // Reset while write and read responses are outstanding
        s_axi.awaddr = 13'h1C; s_axi.awvalid = 1'b1;
        s_axi.wdata = 32'h0000_0055; s_axi.wvalid = 1'b1;
        s_axi.araddr = 13'h14; s_axi.arvalid = 1'b1;
        tick();
        s_axi.arvalid = 1'b0;
        lat = 0;
        while (!s_axi.bvalid && lat < 10) begin
            if (s_axi.awready == 1'b0) s_axi.awvalid = 1'b0;
            if (s_axi.wready == 1'b0) s_axi.wvalid = 1'b0;
            tick();
            lat++;
        end
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        check("pending_bvalid", 32'(s_axi.bvalid), 32'd1);
        check("pending_rvalid", 32'(s_axi.rvalid), 32'd1);
        rstn = 1'b0;
        tick();
        check("rst_drop_bvalid", 32'(s_axi.bvalid), 32'd0);
        check("rst_drop_rvalid", 32'(s_axi.rvalid), 32'd0);
        rstn = 1'b1;
        tick();
        axi_read(13'h1C, rd, rsp);
        check("scr_after_reset", rd, 32'h00);
        axi_read(13'h4, rd, rsp);
        check("ier_after_reset", rd, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axil_uart_vport.md
Name: axil_uart_vport

Overview:
- AXI4-Lite slave that terminates the 13-bit/32-bit UART AXI-Lite port and the uart_irq line of the MEEP-shell OpenPiton wrapper.
- Presents a 16550-compatible register subset with reg-shift 2, so existing firmware drivers run unchanged.
- Replaces the serial PHY with byte streams (valid/ready) that the shell bridges to the host console.
- Synthesised on chipset_clk.

Parameters:
- FIFO_DEPTH, 16, entries in each of the TX and RX byte FIFOs (power of two, ≥2).
- ADDR_W, 13, AXI-Lite address width.

Ports:
- chipset_clk  in  1  sole clock.
- chipset_rstn  in  1  reset, synchronous, active-low.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid  in  1
- s_axi_awready  out  1
- s_axi_wdata  in  32  write data; only [7:0] used; no strobes.
- s_axi_wvalid  in  1
- s_axi_wready  out  1
- s_axi_bresp  out  2
- s_axi_bvalid  out  1
- s_axi_bready  in  1
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arvalid  in  1
- s_axi_arready  out  1
- s_axi_rdata  out  32
- s_axi_rresp  out  2
- s_axi_rvalid  out  1
- s_axi_rready  in  1
- tx_byte  out  8  console TX stream data.
- tx_valid  out  1
- tx_ready  in  1
- rx_byte  in  8  console RX stream data.
- rx_valid  in  1
- rx_ready  out  1
- uart_irq  out  1  level interrupt to the core.

Behaviour:
- Single clock chipset_clk; reset chipset_rstn is synchronous, active-low.
- Reset values (next edge with chipset_rstn=0):
  - Outputs: awready, wready, bvalid, arready, rvalid, tx_valid, rx_ready, uart_irq all 0; bresp, rresp, rdata all 0.
  - Registers: IER, LCR, MCR, SCR, DLL, DLM = 0.
  - State: both FIFOs empty; any latched AW/W/AR is discarded.
- Reset mid-transaction: outstanding B/R responses are dropped, not completed.
- Register index = addr[4:2].
  - Any address with addr[ADDR_W-1:5] ≠ 0 is unmapped: response SLVERR (2'b10), no side effect, rdata 0.
  - Mapped accesses respond OKAY (2'b00).
- Registers (DLAB = LCR[7]):
  - idx 0: read RBR (pop RX) / write THR (push TX); with DLAB=1, DLL R/W.
  - idx 1: IER[1:0] (bit0 = RX-data enable, bit1 = THR-empty enable); with DLAB=1, DLM R/W.
  - idx 2: read IIR; write FCR (bit1 clears RX FIFO, bit2 clears TX FIFO, other bits ignored).
  - idx 3: LCR, 8-bit R/W.
  - idx 4: MCR, 8-bit R/W.
  - idx 5: LSR, read-only. bit0 DR = RX non-empty; bit5 THRE = TX empty; bit6 TEMT = TX empty; other bits 0.
  - idx 6: MSR, read-only 0xB0.
  - idx 7: SCR, 8-bit R/W.
  - Writes to read-only registers are ignored and still return OKAY.
  - rdata[31:8] = 0.
- IIR value: 0xC4 if IER[0] & DR; else 0xC2 if IER[1] & THRE; else 0xC1. IIR reads have no side effect.
- uart_irq: registered version of (IER[0]&DR) | (IER[1]&THRE); one cycle after the cause changes.
- Write channel:
  - awready = !aw_held & !bvalid; wready = !w_held & !bvalid.
  - AW and W may arrive in either order or together; each is latched on its handshake.
  - The cycle after both are held, the write executes and bvalid rises. Minimum AW+W-to-bvalid latency is 1 cycle.
  - bvalid holds until bready; the held flags clear when the write executes.
- Read channel:
  - arready = !rvalid.
  - On AR handshake, rdata/rresp register and rvalid rises next cycle, held stable until rready.
  - RBR pop happens at AR handshake.
  - RBR read with RX empty returns 0x00, no pop.
- TX FIFO:
  - tx_valid = !empty; tx_byte = head; pop on tx_valid & tx_ready.
  - THR write when count = FIFO_DEPTH at start of the cycle: byte silently dropped, even if a pop occurs the same cycle.
- RX FIFO:
  - rx_ready = (count < FIFO_DEPTH) & chipset_rstn; push on rx_valid & rx_ready.
  - Back-pressure only, so no overrun is possible.
- Simultaneous push and pop on one FIFO: both occur, count unchanged; the empty-FIFO push is not visible at the head until the next cycle.
- FCR clear in the same cycle as a push or pop: clear wins; FIFO empty afterwards.
- Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.

Test Plan:
- Reset, then read idx 5 (addr 0x14) -> rdata 0x60, rresp 00; tx_valid 0; rx_ready 1; uart_irq 0.
- Write 0x41 to addr 0x0 with W one cycle before AW, tx_ready=0 -> bvalid exactly 1 cycle after AW; tx_valid 1, tx_byte 0x41; raise tx_ready -> tx_valid 0 next cycle, LSR reads 0x60.
- tx_ready=0, 17 THR writes 0x00..0x10 -> bytes 0x00..0x0F emerge in order, 0x10 dropped, all 17 bresp 00.
- IER=0x01, drive rx_byte 0x5A with rx_valid for 1 cycle -> uart_irq 1 within 2 cycles, IIR 0xC4; read addr 0x0 -> 0x5A, then uart_irq 0, LSR bit0 0.
- rx_valid held with 16 distinct bytes and no reads -> rx_ready 0 after 16th; FCR write 0x02 -> rx_ready 1, LSR bit0 0.
- Read addr 0x40 -> rresp 10, rdata 0. Write LCR 0x80 then 0x12 to addr 0x0 -> DLL readback 0x12, TX FIFO untouched. Assert reset while bvalid pending -> bvalid 0 next edge.
